// File: rtl/child_status_collector.sv
`default_nettype none
// ============================================================================
// child_status_collector: round-robin fan-in of N_CHILD child status tokens
// into one registered valid/ready output stage.  Revision: 1.0
// ============================================================================
module child_status_collector #(
  parameter int N_CHILD = 5,
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CHILD-1:0]          child_valid,
  input  logic [N_CHILD*DATA_W-1:0]   child_data,
  output logic [N_CHILD-1:0]          child_ready,
  output logic                        up_valid,
  output logic [DATA_W-1:0]           up_data,
  output logic [IDX_W-1:0]            up_idx,
  input  logic                        up_ready,
  output logic [15:0]                 tok_count
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   up_data_q, up_data_d;
  logic [IDX_W-1:0]    up_idx_q, up_idx_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [15:0]         tok_count_q, tok_count_d;

  logic                load_en;
  logic                grant_found;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W:0]      cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      up_data_q   <= '0;
      up_idx_q    <= '0;
      rr_ptr_q    <= '0;
      tok_count_q <= '0;
    end else begin
      state_q     <= state_d;
      up_data_q   <= up_data_d;
      up_idx_q    <= up_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      tok_count_q <= tok_count_d;
    end
  end

  always_comb begin
    load_en     = (state_q == ST_EMPTY) | up_ready;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    // First valid child at or after rr_ptr, wrapping modulo N_CHILD.
    for (int k = 0; k < N_CHILD; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_CHILD)) begin
        cand = cand - (IDX_W+1)'(N_CHILD);
      end
      if (!grant_found && child_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    up_data_d   = up_data_q;
    up_idx_d    = up_idx_q;
    rr_ptr_d    = rr_ptr_q;
    tok_count_d = tok_count_q;
    child_ready = '0;

    if ((state_q == ST_FULL) && up_ready && (tok_count_q != 16'hFFFF)) begin
      tok_count_d = tok_count_q + 16'd1;
    end

    if (load_en && grant_found) begin
      child_ready[grant_idx] = 1'b1;
      state_d   = ST_FULL;
      up_data_d = child_data[int'(grant_idx)*DATA_W +: DATA_W];
      up_idx_d  = grant_idx;
      rr_ptr_d  = (grant_idx == IDX_W'(N_CHILD-1)) ? '0 : grant_idx + IDX_W'(1);
    end else if ((state_q == ST_FULL) && up_ready) begin
      state_d = ST_EMPTY;
    end

    // Children must see no acceptance while the block is held in reset.
    if (!rst_n) begin
      child_ready = '0;
    end
  end

  assign up_valid  = (state_q == ST_FULL);
  assign up_data   = up_data_q;
  assign up_idx    = up_idx_q;
  assign tok_count = tok_count_q;

endmodule
`default_nettype wire

// File: tb/tb_child_status_collector.sv
`default_nettype none
// Testbench for child_status_collector: directed scenarios plus randomized
// traffic compared against a behavioural reference model.
module tb_child_status_collector;

  localparam int N  = 5;
  localparam int DW = 16;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    child_valid;
  logic [N*DW-1:0] child_data;
  logic [N-1:0]    child_ready;
  logic            up_valid;
  logic [DW-1:0]   up_data;
  logic [IW-1:0]   up_idx;
  logic            up_ready;
  logic [15:0]     tok_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_rr;
  bit          m_valid;
  logic [15:0] m_data;
  int          m_idx;
  int          m_cnt;

  child_status_collector #(.N_CHILD(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .child_valid (child_valid),
    .child_data  (child_data),
    .child_ready (child_ready),
    .up_valid    (up_valid),
    .up_data     (up_data),
    .up_idx      (up_idx),
    .up_ready    (up_ready),
    .tok_count   (tok_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void m_reset();
    m_rr = 0; m_valid = 0; m_data = '0; m_idx = 0; m_cnt = 0;
  endfunction

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_rr + k) % N;
      if (child_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = m_grant();
    if ((!m_valid || up_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic void m_clock();
    int g;
    bit le;
    g  = m_grant();
    le = !m_valid || up_ready;
    if (m_valid && up_ready && m_cnt < 65535) m_cnt++;
    if (le && g >= 0) begin
      m_data  = child_data[g*DW +: DW];
      m_idx   = g;
      m_valid = 1;
      m_rr    = (g + 1) % N;
    end else if (m_valid && up_ready) begin
      m_valid = 0;
    end
  endfunction

  task automatic adv();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; child_valid = '0; child_data = '0; up_ready = 1'b0;
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; child_valid = '1; child_data = '0; up_ready = 1'b1;
    m_reset();
    @(negedge clk);
    checks++; if (child_ready !== 5'b0) begin errors++; $display("FAIL reset_ready: got %b want 00000", child_ready); end
    checks++; if (up_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", up_valid); end
    checks++; if (tok_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %h want 0000", tok_count); end
    @(posedge clk); #1;
    rst_n = 1'b1; child_valid = 5'b00100; child_data[2*DW +: DW] = 16'h1234; up_ready = 1'b0;
    @(negedge clk);
    checks++; if (child_ready !== 5'b00100) begin errors++; $display("FAIL first_ready: got %b want 00100", child_ready); end
    adv();
    child_valid = '0;
    @(negedge clk);
    checks++; if (up_valid !== 1'b1 || up_data !== 16'h1234 || up_idx !== 3'd2) begin
      errors++; $display("FAIL first_token: got v=%b d=%h i=%0d want v=1 d=1234 i=2", up_valid, up_data, up_idx);
    end
  endtask

  task automatic test_round_robin();
    reset_dut();
    for (int i = 0; i < N; i++) child_data[i*DW +: DW] = 16'hA000 + 16'(i);
    child_valid = '1; up_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      adv();
      @(negedge clk);
      checks++; if (up_idx !== IW'(c % N) || up_data !== 16'hA000 + 16'(c % N)) begin
        errors++; $display("FAIL rr_seq[%0d]: got i=%0d d=%h want i=%0d d=%h", c, up_idx, up_data, c % N, 16'hA000 + 16'(c % N));
      end
    end
    child_valid = '0;
    adv();
    @(negedge clk);
    checks++; if (tok_count !== 16'd10 || up_valid !== 1'b0) begin
      errors++; $display("FAIL rr_count: got cnt=%0d v=%b want cnt=10 v=0", tok_count, up_valid);
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    child_valid = 5'b00010; child_data[1*DW +: DW] = 16'h0011; up_ready = 1'b0;
    adv();
    child_valid = 5'b01001; child_data[0 +: DW] = 16'h0F00; child_data[3*DW +: DW] = 16'h0333;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (child_ready !== 5'b0 || up_valid !== 1'b1 || up_data !== 16'h0011 || up_idx !== 3'd1) begin
        errors++; $display("FAIL bp_hold[%0d]: got r=%b v=%b d=%h i=%0d want r=00000 v=1 d=0011 i=1", c, child_ready, up_valid, up_data, up_idx);
      end
      adv();
    end
    up_ready = 1'b1;
    @(negedge clk);
    checks++; if (child_ready !== 5'b01000) begin errors++; $display("FAIL bp_release_ready: got %b want 01000", child_ready); end
    adv();
    up_ready = 1'b0;
    @(negedge clk);
    checks++; if (up_valid !== 1'b1 || up_data !== 16'h0333 || up_idx !== 3'd3 || tok_count !== 16'd1) begin
      errors++; $display("FAIL bp_release_load: got v=%b d=%h i=%0d c=%0d want v=1 d=0333 i=3 c=1", up_valid, up_data, up_idx, tok_count);
    end
  endtask

  task automatic test_sparse();
    logic [15:0] v;
    reset_dut();
    up_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      v = 16'($urandom);
      child_valid = 5'b10000; child_data[4*DW +: DW] = v;
      @(negedge clk);
      checks++; if (child_ready !== 5'b10000) begin errors++; $display("FAIL sparse_ready[%0d]: got %b want 10000", t, child_ready); end
      adv();
      child_valid = '0;
      @(negedge clk);
      checks++; if (up_valid !== 1'b1 || up_idx !== 3'd4 || up_data !== v) begin
        errors++; $display("FAIL sparse_tok[%0d]: got v=%b i=%0d d=%h want v=1 i=4 d=%h", t, up_valid, up_idx, up_data, v);
      end
      adv();
      @(negedge clk);
      checks++; if (up_valid !== 1'b0) begin errors++; $display("FAIL sparse_gap[%0d]: got v=%b want 0", t, up_valid); end
      adv();
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    child_valid = 5'b00100; child_data[2*DW +: DW] = 16'hBEEF; up_ready = 1'b0;
    adv();
    child_valid = 5'b01010;
    @(negedge clk);
    checks++; if (up_valid !== 1'b1 || up_data !== 16'hBEEF) begin
      errors++; $display("FAIL mid_full: got v=%b d=%h want v=1 d=BEEF", up_valid, up_data);
    end
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    checks++; if (up_valid !== 1'b0 || child_ready !== 5'b0) begin
      errors++; $display("FAIL mid_async: got v=%b r=%b want v=0 r=00000", up_valid, child_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; up_ready = 1'b1;
    @(negedge clk);
    checks++; if (child_ready !== 5'b00010) begin errors++; $display("FAIL mid_regrant: got %b want 00010", child_ready); end
    adv();
    child_valid = '0;
    @(negedge clk);
    checks++; if (up_idx !== 3'd1 || up_valid !== 1'b1) begin
      errors++; $display("FAIL mid_idx: got i=%0d v=%b want i=1 v=1", up_idx, up_valid);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_r;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!child_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            child_valid[i] = 1'b1;
            child_data[i*DW +: DW] = 16'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          child_valid[i] = 1'b0;
        end
      end
      up_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_r = m_ready();
      checks++; if (child_ready !== exp_r) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, child_ready, exp_r); end
      checks++; if (up_valid !== m_valid || tok_count !== 16'(m_cnt)) begin
        errors++; $display("FAIL rnd_state[%0d]: got v=%b c=%0d want v=%b c=%0d", c, up_valid, tok_count, m_valid, m_cnt);
      end
      if (m_valid) begin
        checks++; if (up_data !== m_data || up_idx !== IW'(m_idx)) begin
          errors++; $display("FAIL rnd_token[%0d]: got d=%h i=%0d want d=%h i=%0d", c, up_data, up_idx, m_data, m_idx);
        end
      end
      adv();
      child_valid = child_valid & ~exp_r;
    end
  endtask

  task automatic test_saturation();
    int guard;
    reset_dut();
    child_valid = 5'b00001; child_data[0 +: DW] = 16'h5A5A; up_ready = 1'b1;
    guard = 0;
    while (m_cnt < 65534 && guard < 70000) begin
      adv();
      guard++;
    end
    @(negedge clk);
    checks++; if (tok_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want FFFE", tok_count); end
    for (int t = 0; t < 3; t++) adv();
    @(negedge clk);
    checks++; if (tok_count !== 16'hFFFF) begin errors++; $display("FAIL sat_top: got %h want FFFF", tok_count); end
    for (int t = 0; t < 3; t++) adv();
    @(negedge clk);
    checks++; if (tok_count !== 16'hFFFF || up_valid !== 1'b1) begin
      errors++; $display("FAIL sat_hold: got c=%h v=%b want c=FFFF v=1", tok_count, up_valid);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
